// File: rtl/rtc_bus_ctrl_if.sv
// RTC parallel-bus transfer interface: request side from the menu FSM plus the
// multiplexed AD bus pins. master = bus controller, slave = its counterpart.
interface rtc_bus_ctrl_if;
   logic       Acceso;
   logic       Mod;
   logic [7:0] Dir;
   logic [7:0] Dato_esc;
   logic [7:0] AD_in;
   logic [7:0] AD_out;
   logic       AD_oe;
   logic       CS_n;
   logic       AD_sel_n;
   logic       RD_n;
   logic       WR_n;
   logic [7:0] Dato_lec;
   logic       FRW;
   logic       ocupado;

   modport master (
      input  Acceso, Mod, Dir, Dato_esc, AD_in,
      output AD_out, AD_oe, CS_n, AD_sel_n, RD_n, WR_n, Dato_lec, FRW, ocupado
   );

   modport slave (
      output Acceso, Mod, Dir, Dato_esc, AD_in,
      input  AD_out, AD_oe, CS_n, AD_sel_n, RD_n, WR_n, Dato_lec, FRW, ocupado
   );
endinterface

// File: rtl/rtc_bus_ctrl.sv
// RTC bus-transaction engine: one address phase plus read/write data phase per request.
// Define RTC_INIT_EN to run the two RTC initialisation writes after reset.
module rtc_bus_ctrl #(
   parameter int T_PULSE = 4,
   parameter int T_GAP   = 2
) (
   input  logic          CLK,
   input  logic          RST,
   rtc_bus_ctrl_if.master bus
);

   localparam logic [2:0] S_INIT = 3'd0, S_IDLE = 3'd1, S_ADDR = 3'd2, S_GAP1 = 3'd3,
                          S_DATA = 3'd4, S_GAP2 = 3'd5, S_DONE = 3'd6;
   localparam logic [7:0] TP_LAST = 8'(T_PULSE - 1);
   localparam logic [7:0] TG_LAST = 8'(T_GAP - 1);

   logic [2:0] state_q, state_d;
   logic [7:0] timer_q, timer_d;
   logic [1:0] init_idx_q, init_idx_d;
   logic       acceso_ant_q, acceso_ant_d;
   logic       mod_q, mod_d;
   logic [7:0] dir_q, dir_d;
   logic [7:0] wdat_q, wdat_d;
   logic [7:0] dato_lec_q, dato_lec_d;
   logic       cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d, sel_n_q, sel_n_d;
   logic       oe_q, oe_d, frw_q, frw_d;
   logic [7:0] ad_out_q, ad_out_d;
   logic       start;

   always_comb begin
      state_d      = state_q;
      init_idx_d   = init_idx_q;
      mod_d        = mod_q;
      dir_d        = dir_q;
      wdat_d       = wdat_q;
      dato_lec_d   = dato_lec_q;
      acceso_ant_d = bus.Acceso;
      start        = bus.Acceso & ~acceso_ant_q;

      case (state_q)
         S_INIT: begin
`ifdef RTC_INIT_EN
            state_d = S_ADDR;
            mod_d   = 1'b1;
            dir_d   = 8'h02;
            wdat_d  = 8'h10;
`else
            // First step also spans the reset-release cycle, so the two pulses land two cycles apart
            if (timer_q == 8'd1 || init_idx_q != 2'd0) state_d = S_DONE;
`endif
         end
         S_IDLE: if (start) begin
            mod_d   = bus.Mod;
            dir_d   = bus.Dir;
            wdat_d  = bus.Dato_esc;
            state_d = S_ADDR;
         end
         S_ADDR: if (timer_q == TP_LAST) state_d = S_GAP1;
         S_GAP1: if (timer_q == TG_LAST) state_d = S_DATA;
         S_DATA: begin
            if (!mod_q && timer_q == TP_LAST) dato_lec_d = bus.AD_in;
            if (timer_q == TP_LAST) state_d = S_GAP2;
         end
         S_GAP2: if (timer_q == TG_LAST) state_d = S_DONE;
         S_DONE: begin
            state_d = S_IDLE;
            if (init_idx_q == 2'd0) begin
               init_idx_d = 2'd1;
`ifdef RTC_INIT_EN
               state_d = S_ADDR;
               wdat_d  = 8'h00;
`else
               state_d = S_INIT;
`endif
            end else if (init_idx_q == 2'd1) begin
               init_idx_d = 2'd2;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d != state_q)      timer_d = 8'd0;
      else if (state_q != S_IDLE)  timer_d = timer_q + 8'd1;
      else                         timer_d = timer_q;

      // Bus pins are registered from the next state so the strobes come straight off flops
      cs_n_d   = 1'b1;
      rd_n_d   = 1'b1;
      wr_n_d   = 1'b1;
      sel_n_d  = 1'b1;
      oe_d     = 1'b0;
      ad_out_d = 8'h00;
      case (state_d)
         S_ADDR: begin
            cs_n_d   = 1'b0;
            sel_n_d  = 1'b0;
            wr_n_d   = 1'b0;
            oe_d     = 1'b1;
            ad_out_d = dir_d;
         end
         S_DATA: begin
            cs_n_d = 1'b0;
            if (mod_d) begin
               wr_n_d   = 1'b0;
               oe_d     = 1'b1;
               ad_out_d = wdat_d;
            end else begin
               rd_n_d = 1'b0;
            end
         end
         default: ;
      endcase
      frw_d = (state_d == S_DONE);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= S_INIT;
         timer_q      <= 8'd0;
         init_idx_q   <= 2'd0;
         acceso_ant_q <= 1'b0;
         mod_q        <= 1'b0;
         dir_q        <= 8'h00;
         wdat_q       <= 8'h00;
         dato_lec_q   <= 8'h00;
         cs_n_q       <= 1'b1;
         rd_n_q       <= 1'b1;
         wr_n_q       <= 1'b1;
         sel_n_q      <= 1'b1;
         oe_q         <= 1'b0;
         ad_out_q     <= 8'h00;
         frw_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         init_idx_q   <= init_idx_d;
         acceso_ant_q <= acceso_ant_d;
         mod_q        <= mod_d;
         dir_q        <= dir_d;
         wdat_q       <= wdat_d;
         dato_lec_q   <= dato_lec_d;
         cs_n_q       <= cs_n_d;
         rd_n_q       <= rd_n_d;
         wr_n_q       <= wr_n_d;
         sel_n_q      <= sel_n_d;
         oe_q         <= oe_d;
         ad_out_q     <= ad_out_d;
         frw_q        <= frw_d;
      end
   end

   assign bus.CS_n     = cs_n_q;
   assign bus.RD_n     = rd_n_q;
   assign bus.WR_n     = wr_n_q;
   assign bus.AD_sel_n = sel_n_q;
   assign bus.AD_oe    = oe_q;
   assign bus.AD_out   = ad_out_q;
   assign bus.Dato_lec = dato_lec_q;
   assign bus.FRW      = frw_q;
   assign bus.ocupado  = (state_q != S_IDLE);

endmodule
